fir_filter_param: RTL and testbench
===================================

Name: fir_filter_param

Overview:
- Parametrised, pipelined streaming FIR filter; successor to the fixed 8-bit-in/16-bit-out FIR_Filter.
- Generalises width, tap count and output scaling. Adds a sample-valid handshake, run-time coefficient loading, synchronous flush and output saturation with a flag.
- Sits between a sample source and downstream DSP logic in the filter datapath.

Parameters:
- DATA_W, 8: input sample width, signed two's complement.
- COEF_W, 8: coefficient width, signed.
- TAPS, 4: number of taps, >=2.
- OUT_W, 16: output width, signed.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- COEF_INIT, all taps = 1: packed TAPS*COEF_W reset coefficient values; tap 0 is in the LSBs.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of the delay line and pipeline.
- x_in  in  DATA_W  input sample.
- x_valid  in  1  x_in is accepted on this edge.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  tap index to write.
- coef_wdata  in  COEF_W  coefficient value.
- y_out  out  OUT_W  filtered sample.
- y_valid  out  1  y_out holds a new result (one-cycle pulse per accepted sample).
- y_sat  out  1  y_out was clipped; qualified by y_valid.

Behaviour:
- Reset (async): delay line = 0, coefficients = COEF_INIT, stage valids = 0, y_out = 0, y_valid = 0, y_sat = 0.
- ACC_W = DATA_W + COEF_W + clog2(TAPS); the sum is full precision, with no intermediate overflow.
- Stage 0, on an edge with x_valid = 1: tap[0] <= x_in and tap[k] <= tap[k-1]. With x_valid = 0 the delay line holds.
- Stage 1, next edge: p[k] <= tap[k] * coef[k] (signed), registered; v1 <= stage-0 accept.
- Stage 2, next edge:
  - acc = sum of p[k], then shifted arithmetically right by SHIFT.
  - acc > 2^(OUT_W-1)-1 clips to the maximum; acc < -2^(OUT_W-1) clips to the minimum.
  - y_out <= the clipped value; y_sat <= 1 when clipped; y_valid <= v1.
- Latency: y_valid rises 2 clocks after the edge that accepted the sample. Full throughput: one sample per clock.
- When y_valid = 0, y_out and y_sat hold their previous values.
- Coefficient write: coef[coef_addr] <= coef_wdata on an edge with coef_we = 1.
  - A sample accepted on the same edge uses the old coefficient in stage 1 only if stage 1 fires before the write.
  - Required: the new coefficient applies to stage-1 products registered on the edge after the write edge.
  - Results already in stage 2 are unaffected.
- coef_addr >= TAPS (non-power-of-2 TAPS): the write is ignored.
- flush = 1:
  - Next edge: delay line = 0, v1 = 0, y_valid = 0.
  - Coefficients and y_out are retained.
  - flush with x_valid in the same cycle: flush wins and the sample is dropped.
  - flush with coef_we in the same cycle: the write still happens.
- Reset asserted mid-stream: all in-flight results are discarded; no y_valid is produced from pre-reset samples.
- Start-up: the delay line begins at zero, so the first TAPS-1 outputs are partial sums. This is not flagged.

Decomposition:
- Shared package fir_pkg holds:
  - the ACC_W function;
  - the saturate(value, OUT_W) function;
  - the SAT_MAX and SAT_MIN constant functions;
  - the packed coefficient-vector typedef used by COEF_INIT.
- One natural sub-module, fir_sat_shift: combinational shift and saturate from ACC_W to OUT_W, producing value and flag. It is reusable by the future decimator.
- The delay line, multipliers and adder stay in the top module as generate loops.

Test Plan:
- Impulse, default coefficients (all 1): apply reset, then x = 1, 2, 3, 4, 5, 6 on consecutive edges. Required: y_out = 1, 3, 6, 10, 14, 18, with y_valid high for 6 cycles starting 2 clocks after the first accept.
- Gapped input: the same samples with x_valid low on alternate cycles. Required: identical y_out sequence, y_valid high only 2 clocks after each accept, y_out held between pulses.
- Coefficient load: write coefficients 1, 2, 3, 4 to taps 0-3, then input a single 1 followed by zeros. Required: y_out = 1, 2, 3, 4, 0.
- Saturation: all coefficients = 127, x = 127 held for 4 samples. Required: the 4th output is 32767 with y_sat = 1 (raw 64516). With x = -128: the 4th output is -32768 with y_sat = 1.
- Flush: stream 1, 2, 3, then flush together with x = 9. Required: no y_valid for 9 and none in the 2 cycles after the flush. The next sample 5 gives y_out = 5 (delay line cleared); coefficients are unchanged.
- Async reset mid-stream: assert rst between clock edges while y_valid would be pending. Required: y_out = 0 and y_valid = 0 immediately, no stale pulse after release, coefficients back to COEF_INIT.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the parametrised FIR filter family.
//   acc_w()      : full-precision accumulator width for a given configuration
//   SAT_MAX/MIN  : signed limits of an out_w-bit result
//   saturate()   : clip a wide signed value into the out_w-bit range
//   coef_vec_t   : packed coefficient vector of the default configuration
//                  (tap 0 in the LSBs)
package fir_pkg;

  localparam int unsigned DEF_TAPS   = 4;
  localparam int unsigned DEF_COEF_W = 8;

  typedef logic [DEF_TAPS*DEF_COEF_W-1:0] coef_vec_t;

  localparam coef_vec_t COEF_ONES = {DEF_TAPS{DEF_COEF_W'(1)}};

  // Product width plus growth for summing taps products.
  function automatic int unsigned acc_w(int unsigned data_w, int unsigned coef_w,
                                        int unsigned taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic logic signed [63:0] SAT_MAX(int unsigned out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] SAT_MIN(int unsigned out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

  function automatic logic signed [63:0] saturate(logic signed [63:0] value,
                                                  int unsigned out_w);
    if (value > SAT_MAX(out_w)) return SAT_MAX(out_w);
    if (value < SAT_MIN(out_w)) return SAT_MIN(out_w);
    return value;
  endfunction

endpackage

// File: rtl/fir_sat_shift.sv
// Combinational arithmetic right shift followed by saturation.
//   i_acc   : signed accumulator, IN_W bits
//   o_value : shifted and clipped result, OUT_W bits
//   o_sat   : high when the shifted value lay outside the OUT_W range
module fir_sat_shift
  import fir_pkg::*;
#(
  parameter int unsigned IN_W  = 18,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  i_acc,
  output logic signed [OUT_W-1:0] o_value,
  output logic                    o_sat
);

  logic signed [IN_W-1:0] w_shifted;
  logic signed [63:0]     w_wide;
  logic signed [63:0]     w_clip;

  always_comb begin
    w_shifted = i_acc >>> SHIFT;
    w_wide    = 64'(w_shifted);
    w_clip    = saturate(w_wide, OUT_W);
    o_value   = OUT_W'(w_clip);
    o_sat     = (w_clip != w_wide);
  end

endmodule

// File: rtl/fir_filter_param.sv
// Parametrised, pipelined streaming FIR filter.
//   clk, rst              : clock, asynchronous active-high reset
//   flush                 : synchronous clear of delay line and in-flight results
//   x_in, x_valid         : input sample and its accept strobe
//   coef_we/addr/wdata    : run-time coefficient write port
//   y_out, y_valid, y_sat : filtered sample, one-cycle result pulse, clip flag
// Pipeline: accept edge -> product edge -> sum/saturate edge (y_valid two
// clocks after the accept edge), one sample per clock.
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 4,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 0,
  parameter logic [TAPS*COEF_W-1:0] COEF_INIT = {TAPS{COEF_W'(1)}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic signed [DATA_W-1:0]  x_in,
  input  logic                      x_valid,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_wdata,
  output logic signed [OUT_W-1:0]   y_out,
  output logic                      y_valid,
  output logic                      y_sat
);

  localparam int unsigned ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [DATA_W-1:0] w_tap  [TAPS];
  logic signed [COEF_W-1:0] r_coef [TAPS];
  logic signed [PROD_W-1:0] w_prod [TAPS];
  logic signed [ACC_W-1:0]  w_psum [TAPS];
  logic                     r_v0;
  logic                     r_v1;
  logic signed [OUT_W-1:0]  w_sat_value;
  logic                     w_sat_flag;

  // Coefficient bank; out-of-range addresses (non-power-of-2 TAPS) are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        r_coef[k] <= COEF_INIT[k*COEF_W +: COEF_W];
      end
    end else if (coef_we && (32'(coef_addr) < TAPS)) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  // Stage valids: r_v0 marks an accept on the previous edge, r_v1 a product set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else if (flush) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else begin
      r_v0 <= x_valid;
      r_v1 <= r_v0;
    end
  end

  // Delay line and multipliers, one register per tap.
  for (genvar g = 0; g < TAPS; g++) begin : g_tap
    logic signed [DATA_W-1:0] r_tap;
    logic signed [PROD_W-1:0] r_prod;

    if (g == 0) begin : g_head
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_tap <= '0;
        else if (flush)   r_tap <= '0;
        else if (x_valid) r_tap <= x_in;
      end
    end else begin : g_body
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_tap <= '0;
        else if (flush)   r_tap <= '0;
        else if (x_valid) r_tap <= w_tap[g-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_prod <= '0;
      else     r_prod <= PROD_W'(r_tap) * PROD_W'(r_coef[g]);
    end

    assign w_tap[g]  = r_tap;
    assign w_prod[g] = r_prod;
  end

  // Full-precision adder chain.
  assign w_psum[0] = ACC_W'(w_prod[0]);
  for (genvar g = 1; g < TAPS; g++) begin : g_sum
    assign w_psum[g] = w_psum[g-1] + ACC_W'(w_prod[g]);
  end

  fir_sat_shift #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .i_acc   (w_psum[TAPS-1]),
    .o_value (w_sat_value),
    .o_sat   (w_sat_flag)
  );

  // Output stage; y_out/y_sat only move with a result, flush keeps them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_out   <= '0;
      y_valid <= 1'b0;
      y_sat   <= 1'b0;
    end else begin
      y_valid <= r_v1 && !flush;
      if (r_v1 && !flush) begin
        y_out <= w_sat_value;
        y_sat <= w_sat_flag;
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_param.sv
module tb_fir_filter_param;

  localparam int TAPS  = 4;
  localparam int SHIFT = 0;
  localparam int YMAX  = 32767;
  localparam int YMIN  = -32768;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic signed [7:0]  x_in;
  logic               x_valid;
  logic               coef_we;
  logic [1:0]         coef_addr;
  logic signed [7:0]  coef_wdata;
  logic signed [15:0] y_out;
  logic               y_valid;
  logic               y_sat;

  always #5 clk = ~clk;

  fir_filter_param #(
    .DATA_W (8),
    .COEF_W (8),
    .TAPS   (TAPS),
    .OUT_W  (16),
    .SHIFT  (SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .x_in       (x_in),
    .x_valid    (x_valid),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .y_out      (y_out),
    .y_valid    (y_valid),
    .y_sat      (y_sat)
  );

  typedef struct {
    int due;
    int y;
    int sat;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   hist   [TAPS];
  int   coef_m [TAPS];
  int   last_y   = 0;
  int   last_sat = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic int clip(input int v);
    if (v > YMAX) return YMAX;
    if (v < YMIN) return YMIN;
    return v;
  endfunction

  task automatic model_reset();
    sb.delete();
    hist   = '{default: 0};
    coef_m = '{default: 1};
    last_y   = 0;
    last_sat = 0;
  endtask

  // Drive one edge worth of inputs and record what the filter owes for it.
  task automatic drive(input bit xv, input int x, input bit fl, input bit we,
                       input int addr, input int wd);
    int acc;
    int edge_n;
    @(posedge clk);
    #1;
    x_valid    = xv;
    x_in       = x[7:0];
    flush      = fl;
    coef_we    = we;
    coef_addr  = addr[1:0];
    coef_wdata = wd[7:0];
    edge_n     = cyc + 1;
    if (we && addr < TAPS) coef_m[addr] = wd;
    if (fl) begin
      hist = '{default: 0};
      while (sb.size() > 0 && sb[sb.size()-1].due >= edge_n) void'(sb.pop_back());
    end else if (xv) begin
      for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += hist[k] * coef_m[k];
      acc = acc >>> SHIFT;
      sb.push_back('{edge_n + 2, clip(acc), (clip(acc) != acc) ? 1 : 0});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic stream(input int s0, input int n, input int step);
    for (int i = 0; i < n; i++) drive(1, s0 + i * step, 0, 0, 0, 0);
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
    drive(0, 0, 0, 1, 0, c0);
    drive(0, 0, 0, 1, 1, c1);
    drive(0, 0, 0, 1, 2, c2);
    drive(0, 0, 0, 1, 3, c3);
  endtask

  // Monitor: pops one expectation per y_valid pulse, checks holds otherwise.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (y_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: cycle %0d y_valid=1 y_out=%0d, no result owed",
                   cyc, y_out);
        end else begin
          e = sb.pop_front();
          check("valid_timing", cyc, e.due);
          check("y_out", y_out, e.y);
          check("y_sat", 32'(y_sat), e.sat);
          last_y   = e.y;
          last_sat = e.sat;
        end
      end else begin
        check("y_out_hold", y_out, last_y);
        check("y_sat_hold", 32'(y_sat), last_sat);
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_valid: cycle %0d y_valid=0, result %0d was due at cycle %0d",
                   cyc, sb[0].y, sb[0].due);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    x_in       = '0;
    x_valid    = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    model_reset();
    #2;
    check("reset_y_out", y_out, 0);
    check("reset_y_valid", 32'(y_valid), 0);
    check("reset_y_sat", 32'(y_sat), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Impulse-style ramp with default coefficients: 1,3,6,10,14,18.
    stream(1, 6, 1);
    idle(4);

    // Same samples, gapped, from a cleared delay line.
    drive(0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      drive(1, i, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
    end
    idle(3);

    // Coefficient load then a unit impulse: 1,2,3,4,0.
    load_coefs(1, 2, 3, 4);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    stream(0, 4, 0);
    idle(3);

    // Saturation at both rails.
    load_coefs(127, 127, 127, 127);
    drive(0, 0, 1, 0, 0, 0);
    stream(127, 4, 0);
    stream(-128, 4, 0);
    idle(3);

    // Flush together with a sample, then a fresh sample.
    load_coefs(1, 1, 1, 1);
    drive(0, 0, 1, 0, 0, 0);
    stream(1, 3, 1);
    drive(1, 9, 1, 0, 0, 0);
    idle(2);
    drive(1, 5, 0, 0, 0, 0);
    idle(3);

    // Flush and coefficient write on the same edge: write still lands.
    drive(0, 0, 1, 1, 2, 3);
    drive(1, 2, 0, 0, 0, 0);
    stream(0, 3, 0);
    idle(3);

    // Asynchronous reset while results are in flight.
    load_coefs(5, 6, 7, 8);
    stream(10, 4, 3);
    @(posedge clk);
    #3;
    rst     = 1'b1;
    x_valid = 1'b0;
    flush   = 1'b0;
    coef_we = 1'b0;
    #1;
    check("midrst_y_out", y_out, 0);
    check("midrst_y_valid", 32'(y_valid), 0);
    check("midrst_y_sat", 32'(y_sat), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    drive(1, 1, 0, 0, 0, 0);
    stream(0, 4, 0);
    idle(3);

    // Randomised traffic with sporadic flushes and coefficient writes.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, int'($urandom_range(0, 255)) - 128,
            ($urandom % 25) == 0, ($urandom % 8) == 0,
            int'($urandom % 4), int'($urandom_range(0, 255)) - 128);
    end

    // Drain, bounded.
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results still owed, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
